digit_announce_ctrl: RTL

- Control stage directly upstream of the MP3 playback driver.
- Takes the classifier result stream and qualifies it: a digit must be seen identically for STABLE_CNT consecutive valid samples before it is accepted.
- On acceptance it latches the digit onto `decision` and pulses the player reset, so the driver plays the prompt clip and then the digit clip.
- Also supports a user replay request and a playback timeout, so the player is never restarted mid-clip.

---
 rtl/announce_pkg.sv | 12 +
 rtl/run_length_detector.sv | 58 +++++
 rtl/digit_announce_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/announce_pkg.sv
// Shared definitions for the digit announcement control path.
package announce_pkg;

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] RESTART = 2'd1;
    localparam logic [1:0] PLAY    = 2'd2;

    localparam logic [3:0] DIGIT_MAX       = 4'd9;
    // Driver clip slot that holds the spoken prompt preceding each digit.
    localparam logic [3:0] PROMPT_CLIP_IDX = 4'd10;

endpackage

// File: rtl/run_length_detector.sv
// Qualifies the classifier stream: flags a digit seen STABLE_CNT times in a row.
module run_length_detector
    import announce_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cls_valid,
    input  logic [3:0] cls_digit,
    input  logic       clear,
    input  logic       freeze,
    output logic       stable,
    output logic [3:0] stable_digit
);

    localparam logic [7:0] CNT_TARGET = 8'(STABLE_CNT);

    logic [3:0] r_last_digit;
    logic [7:0] r_cnt;
    logic [3:0] w_next_last;
    logic [7:0] w_next_cnt;
    logic       w_legal;
    logic       w_sample;

    assign w_legal  = (cls_digit <= DIGIT_MAX);
    assign w_sample = cls_valid && !freeze;

    always_comb begin
        w_next_last = r_last_digit;
        w_next_cnt  = r_cnt;
        if (w_sample) begin
            if (!w_legal) begin
                w_next_cnt = '0;
            end else if (cls_digit == r_last_digit) begin
                w_next_cnt = (r_cnt == CNT_TARGET) ? r_cnt : r_cnt + 8'd1;
            end else begin
                w_next_last = cls_digit;
                w_next_cnt  = 8'd1;
            end
        end
    end

    // A saturated run keeps reporting stable; the caller decides whether it is news.
    assign stable       = w_sample && w_legal && (w_next_cnt == CNT_TARGET);
    assign stable_digit = cls_digit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_digit <= '0;
            r_cnt        <= '0;
        end else begin
            r_last_digit <= w_next_last;
            r_cnt        <= clear ? '0 : w_next_cnt;
        end
    end

endmodule

// File: rtl/digit_announce_ctrl.sv
// Latches qualified digits and sequences the MP3 player reset / playback window.
module digit_announce_ctrl
    import announce_pkg::*;
#(
    parameter int unsigned STABLE_CNT   = 8,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned PLAY_TIMEOUT = 12000000,
    parameter int unsigned TIMER_W      = 24
) (
    input  logic       mp3_clk,
    input  logic       rst,
    input  logic       cls_valid,
    input  logic [3:0] cls_digit,
    input  logic       replay_req,
    output logic [3:0] decision,
    output logic       decision_valid,
    output logic       player_rst,
    output logic       busy
);

    localparam logic [7:0]         RST_LAST   = 8'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PLAY_TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [3:0]         r_decision;
    logic               r_decision_valid;
    logic               r_player_rst;
    logic               r_busy;
    logic [7:0]         r_rst_cnt;
    logic [TIMER_W-1:0] r_timer;
    logic               r_replay_q;

    logic               w_stable;
    logic [3:0]         w_stable_digit;
    logic               w_accept;
    logic               w_replay;
    logic               w_freeze;

    assign w_freeze = (r_state != COLLECT);
    assign w_accept = w_stable && (!r_decision_valid || (w_stable_digit != r_decision));
    assign w_replay = replay_req && !r_replay_q && r_decision_valid;

    run_length_detector #(
        .STABLE_CNT(STABLE_CNT)
    ) u_rld (
        .clk         (mp3_clk),
        .rst         (rst),
        .cls_valid   (cls_valid),
        .cls_digit   (cls_digit),
        .clear       (w_accept),
        .freeze      (w_freeze),
        .stable      (w_stable),
        .stable_digit(w_stable_digit)
    );

    always_ff @(posedge mp3_clk) begin
        if (rst) begin
            r_state          <= COLLECT;
            r_decision       <= '0;
            r_decision_valid <= 1'b0;
            r_player_rst     <= 1'b1;
            r_busy           <= 1'b0;
            r_rst_cnt        <= '0;
            r_timer          <= '0;
            r_replay_q       <= 1'b0;
        end else begin
            // Edge history advances in every state so a level held through PLAY is spent.
            r_replay_q <= replay_req;
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        r_decision       <= w_stable_digit;
                        r_decision_valid <= 1'b1;
                        r_busy           <= 1'b1;
                        r_player_rst     <= 1'b1;
                        r_rst_cnt        <= '0;
                        r_state          <= RESTART;
                    end else if (w_replay) begin
                        r_busy       <= 1'b1;
                        r_player_rst <= 1'b1;
                        r_rst_cnt    <= '0;
                        r_state      <= RESTART;
                    end
                end
                RESTART: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_player_rst <= 1'b0;
                        r_timer      <= '0;
                        r_state      <= PLAY;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 8'd1;
                    end
                end
                PLAY: begin
                    if (r_timer == TIMER_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= COLLECT;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                default: begin
                    r_state      <= COLLECT;
                    r_player_rst <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign decision       = r_decision;
    assign decision_valid = r_decision_valid;
    assign player_rst     = r_player_rst;
    assign busy           = r_busy;

endmodule
